// File: rtl/fixed_to_float_pipe.sv
// Three-stage two's-complement fixed-point to IEEE-754 single converter (capture, normalise, pack).
// Define FTF_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates toward zero.
module fixed_to_float_pipe #(
  parameter int unsigned FIXED_W = 32,
  parameter int unsigned FRAC_W  = 30
) (
  input  logic               clock,
  input  logic               aclr,
  input  logic               clk_en,
  input  logic               in_valid,
  input  logic [FIXED_W-1:0] fixed_in,
  output logic               out_valid,
  output logic [31:0]        result
);

  localparam int unsigned EXT_W = FIXED_W + 24;

  logic               v1;
  logic               v2;
  logic               s1_sign;
  logic               s2_sign;
  logic [FIXED_W-1:0] s1_mag;
  logic [FIXED_W-1:0] s2_norm;
  logic [5:0]         s2_p;
  logic               s2_zf;

  logic [FIXED_W-1:0] mag_in;
  logic [5:0]         lead;
  logic [FIXED_W-1:0] norm_next;

  // The most negative input negates to itself, which read as unsigned is exactly 2^(FIXED_W-1).
  assign mag_in = fixed_in[FIXED_W-1] ? (~fixed_in + FIXED_W'(1)) : fixed_in;

  always_comb begin
    lead = '0;
    for (int unsigned i = 0; i < FIXED_W; i++) begin
      if (s1_mag[i]) lead = 6'(i);
    end
  end

  assign norm_next = s1_mag << (6'(FIXED_W - 1) - lead);

  // Padding 24 zeros below the normalised value gives the mantissa, guard and sticky at fixed
  // positions for every FIXED_W; narrow formats simply see zero guard and sticky bits.
  logic [EXT_W-1:0] ext;
  logic [22:0]      mant_raw;
  logic [8:0]       exp_raw;
  logic [22:0]      mant;
  logic [8:0]       exp_sum;

  assign ext      = {s2_norm, 24'b0};
  assign mant_raw = ext[EXT_W-2 -: 23];
  assign exp_raw  = 9'd127 + 9'(s2_p) - 9'(FRAC_W);

`ifdef FTF_ROUND_NEAREST_EN
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] mant_inc;
  logic [1:0]  unused_bits;

  assign guard    = ext[FIXED_W-1];
  assign sticky   = |ext[FIXED_W-2:0];
  assign round_up = guard & (sticky | mant_raw[0]);
  assign mant_inc = {1'b0, mant_raw} + 24'd1;
  assign mant     = round_up ? mant_inc[22:0] : mant_raw;
  assign exp_sum  = exp_raw + 9'(round_up & mant_inc[23]);
  assign unused_bits = {exp_sum[8], ext[EXT_W-1]};
`else
  logic [2:0] unused_bits;

  assign mant        = mant_raw;
  assign exp_sum     = exp_raw;
  assign unused_bits = {exp_sum[8], ext[EXT_W-1], |ext[FIXED_W-1:0]};
`endif

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      s1_sign   <= 1'b0;
      s2_sign   <= 1'b0;
      s1_mag    <= '0;
      s2_norm   <= '0;
      s2_p      <= '0;
      s2_zf     <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (clk_en) begin
      v1        <= in_valid;
      s1_sign   <= fixed_in[FIXED_W-1];
      s1_mag    <= mag_in;
      v2        <= v1;
      s2_sign   <= s1_sign;
      s2_norm   <= norm_next;
      s2_p      <= lead;
      s2_zf     <= (s1_mag == '0);
      out_valid <= v2;
      if (v2) result <= s2_zf ? '0 : {s2_sign, exp_sum[7:0], mant};
    end
  end

endmodule
